// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// load_store_unit
//
// RV32I load/store unit. Takes one LOAD or STORE request at a time from the
// execute stage, checks it for legality and alignment, performs a single-beat
// word-wide data-memory access with byte-lane steering, and retires it with a
// one-cycle DONE pulse (plus WB_VALID for loads, FAULT for faults).
//
// Ports
//   CLK, RESET_N                 clock, asynchronous active-low reset
//   REQ_VALID / REQ_READY        request handshake from execute
//   OPCODE, FUNCT3, ADDR,
//   STORE_DATA, RD               request payload
//   MEM_REQ, MEM_WE, MEM_ADDR,
//   MEM_WSTRB, MEM_WDATA         data-memory request (held until MEM_ACK)
//   MEM_ACK, MEM_RDATA           data-memory completion and read data
//   WB_VALID, WB_RD, WB_DATA     load writeback
//   DONE, FAULT, FAULT_CAUSE     retirement status
//
// Parameter
//   TIMEOUT   cycles to wait for MEM_ACK before faulting; 0 disables
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [6:0]  OPCODE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDR,
    input  logic [31:0] STORE_DATA,
    input  logic [4:0]  RD,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_WSTRB,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic        WB_VALID,
    output logic [4:0]  WB_RD,
    output logic [31:0] WB_DATA,
    output logic        DONE,
    output logic        FAULT,
    output logic [1:0]  FAULT_CAUSE
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] CAUSE_MISALIGNED = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b10;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // Captured request / datapath state
    logic             r_is_load;
    logic [2:0]       r_funct3;
    logic [1:0]       r_lane;
    logic             r_fault;
    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [3:0]       r_mem_wstrb;
    logic [31:0]      r_mem_wdata;
    logic [4:0]       r_wb_rd;
    logic [31:0]      r_wb_data;

    logic             w_is_load;
    logic             w_is_store;
    logic             w_illegal;
    logic             w_misaligned;
    logic             w_accept;
    logic             w_timeout;
    logic [CNT_W-1:0] w_cnt_inc;

    // Byte-lane write enables for a store of the given size at the given lane.
    function automatic logic [3:0] f_wstrb(input logic [2:0] funct3,
                                           input logic [1:0] lane);
        logic [3:0] strb;
        case (funct3[1:0])
            2'b00:   strb = 4'b0001 << lane;
            2'b01:   strb = 4'b0011 << lane;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Replicate the store value across lanes so the strobes pick the right copy.
    function automatic logic [31:0] f_wdata(input logic [2:0]  funct3,
                                            input logic [31:0] data);
        logic [31:0] wd;
        case (funct3[1:0])
            2'b00:   wd = {4{data[7:0]}};
            2'b01:   wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

    // Pull the addressed byte/halfword out of the read word and extend it;
    // FUNCT3[2] selects zero extension (BU/HU).
    function automatic logic [31:0] f_load(input logic [2:0]  funct3,
                                           input logic [1:0]  lane,
                                           input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = rdata[{lane, 3'b000} +: 8];
        h = rdata[{lane[1], 4'b0000} +: 16];
        case (funct3[1:0])
            2'b00:   res = {{24{b[7] & ~funct3[2]}}, b};
            2'b01:   res = {{16{h[15] & ~funct3[2]}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Request classification
    assign w_is_load  = (OPCODE == OP_LOAD);
    assign w_is_store = (OPCODE == OP_STORE);

    always_comb begin
        w_illegal = 1'b1;
        if (w_is_load) begin
            case (FUNCT3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
                default:                                w_illegal = 1'b1;
            endcase
        end else if (w_is_store) begin
            w_illegal = FUNCT3[2] | (FUNCT3[1:0] == 2'b11);
        end
    end

    always_comb begin
        case (FUNCT3[1:0])
            2'b01:   w_misaligned = ADDR[0];
            2'b10:   w_misaligned = (ADDR[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_accept  = REQ_VALID && (r_state == S_IDLE);
    assign w_cnt_inc = r_cnt + 1'b1;
    // MEM_ACK in the same cycle as the timeout takes precedence.
    assign w_timeout = (TIMEOUT != 0) && !MEM_ACK && (w_cnt_inc == CNT_W'(TIMEOUT));

    // FSM state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state and control outputs
    always_comb begin
        w_next    = r_state;
        REQ_READY = 1'b0;
        MEM_REQ   = 1'b0;
        DONE      = 1'b0;
        FAULT     = 1'b0;
        WB_VALID  = 1'b0;
        case (r_state)
            S_IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) begin
                    // Faulting requests skip the memory access entirely.
                    w_next = (w_illegal || w_misaligned) ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                MEM_REQ = 1'b1;
                if (MEM_ACK || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                DONE     = 1'b1;
                FAULT    = r_fault;
                WB_VALID = r_is_load & ~r_fault;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request capture, memory-side registers and load result
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_is_load   <= 1'b0;
            r_funct3    <= 3'b000;
            r_lane      <= 2'b00;
            r_fault     <= 1'b0;
            r_cause     <= 2'b00;
            r_cnt       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wstrb <= 4'b0000;
            r_mem_wdata <= 32'd0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'd0;
        end else begin
            if (w_accept) begin
                r_is_load   <= w_is_load;
                r_funct3    <= FUNCT3;
                r_lane      <= ADDR[1:0];
                r_fault     <= w_illegal | w_misaligned;
                r_cnt       <= '0;
                r_mem_we    <= w_is_store;
                r_mem_addr  <= {ADDR[31:2], 2'b00};
                r_mem_wstrb <= w_is_store ? f_wstrb(FUNCT3, ADDR[1:0]) : 4'b0000;
                r_mem_wdata <= f_wdata(FUNCT3, STORE_DATA);
                r_wb_rd     <= RD;
                // Illegal outranks misaligned.
                if (w_illegal) begin
                    r_cause <= CAUSE_ILLEGAL;
                end else if (w_misaligned) begin
                    r_cause <= CAUSE_MISALIGNED;
                end
            end else if (r_state == S_ACCESS) begin
                if (MEM_ACK) begin
                    if (r_is_load) begin
                        r_wb_data <= f_load(r_funct3, r_lane, MEM_RDATA);
                    end
                end else begin
                    r_cnt <= w_cnt_inc;
                    if (w_timeout) begin
                        r_fault <= 1'b1;
                        r_cause <= CAUSE_TIMEOUT;
                    end
                end
            end
        end
    end

    assign MEM_WE      = r_mem_we;
    assign MEM_ADDR    = r_mem_addr;
    assign MEM_WSTRB   = r_mem_wstrb;
    assign MEM_WDATA   = r_mem_wdata;
    assign WB_RD       = r_wb_rd;
    assign WB_DATA     = r_wb_data;
    assign FAULT_CAUSE = r_cause;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed and randomized transactions against load_store_unit (TIMEOUT = 4).
// Expected values come from a behavioural model that works from access size,
// byte lane and plain shifts/masks/multiplies.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int         TO       = 4;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [6:0]  OPCODE = '0;
    logic [2:0]  FUNCT3 = '0;
    logic [31:0] ADDR = '0;
    logic [31:0] STORE_DATA = '0;
    logic [4:0]  RD = '0;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [3:0]  MEM_WSTRB;
    logic [31:0] MEM_WDATA;
    logic        MEM_ACK = 1'b0;
    logic [31:0] MEM_RDATA = '0;
    logic        WB_VALID;
    logic [4:0]  WB_RD;
    logic [31:0] WB_DATA;
    logic        DONE;
    logic        FAULT;
    logic [1:0]  FAULT_CAUSE;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .OPCODE     (OPCODE),
        .FUNCT3     (FUNCT3),
        .ADDR       (ADDR),
        .STORE_DATA (STORE_DATA),
        .RD         (RD),
        .MEM_REQ    (MEM_REQ),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WSTRB  (MEM_WSTRB),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_ACK    (MEM_ACK),
        .MEM_RDATA  (MEM_RDATA),
        .WB_VALID   (WB_VALID),
        .WB_RD      (WB_RD),
        .WB_DATA    (WB_DATA),
        .DONE       (DONE),
        .FAULT      (FAULT),
        .FAULT_CAUSE(FAULT_CAUSE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: what a request should produce, by access size and lane.
    function automatic void model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] rdata,
                                  output logic flt, output logic [1:0] cause,
                                  output logic [3:0] strb, output logic [31:0] wd,
                                  output logic [31:0] wb, output logic ld);
        int          size;
        int          lane;
        logic        st;
        logic        legal;
        logic [31:0] mask;
        logic [31:0] v;
        ld    = (op == OP_LOAD);
        st    = (op == OP_STORE);
        legal = (ld && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
                (st && (f3 <= 3'd2));
        size  = 1 << f3[1:0];
        lane  = int'(a % 4);
        flt   = 1'b0;
        cause = 2'b00;
        if (!legal) begin
            flt   = 1'b1;
            cause = 2'b01;
        end else if ((a % size) != 0) begin
            flt   = 1'b1;
            cause = 2'b00;
        end
        mask = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        strb = st ? 4'(((1 << size) - 1) << lane) : 4'b0000;
        if (size == 1)      wd = (d & 32'hFF)   * 32'h0101_0101;
        else if (size == 2) wd = (d & 32'hFFFF) * 32'h0001_0001;
        else                wd = d;
        v = (rdata >> (8 * lane)) & mask;
        if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
        wb = v;
    endfunction

    // Issue one request; MEM_ACK is given in ACCESS cycle ack_at (0-based),
    // or never if ack_at < 0 or ack_at >= TO. Called and returns at #1 after
    // a rising edge with the unit idle.
    task automatic run_txn(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                           input int ack_at, input logic [31:0] rdata);
        logic        flt;
        logic [1:0]  cause;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic [31:0] wb;
        logic        ld;
        logic        timed;
        int          ncyc;
        model(op, f3, a, d, rdata, flt, cause, strb, wd, wb, ld);
        chk({nm, ".idle_ready"}, 32'(REQ_READY), 32'd1);
        OPCODE = op; FUNCT3 = f3; ADDR = a; STORE_DATA = d; RD = rd;
        REQ_VALID = 1'b1;
        @(posedge CLK); #1;
        // Scramble the payload so only captured values can be right.
        REQ_VALID = 1'b0;
        OPCODE = 7'($urandom); FUNCT3 = 3'($urandom); ADDR = $urandom;
        STORE_DATA = $urandom; RD = 5'($urandom);
        if (!flt) begin
            timed = !(ack_at >= 0 && ack_at < TO);
            ncyc  = timed ? TO : ack_at + 1;
            for (int k = 0; k < ncyc; k++) begin
                chk({nm, ".mem_req"}, 32'(MEM_REQ), 32'd1);
                chk({nm, ".busy_ready"}, 32'(REQ_READY), 32'd0);
                if (k == 0) begin
                    chk({nm, ".mem_addr"}, MEM_ADDR, a & 32'hFFFF_FFFC);
                    chk({nm, ".mem_we"}, 32'(MEM_WE), 32'(!ld));
                    chk({nm, ".mem_wstrb"}, 32'(MEM_WSTRB), 32'(strb));
                    if (!ld) chk({nm, ".mem_wdata"}, MEM_WDATA, wd);
                end
                if (k == ack_at) begin
                    MEM_ACK = 1'b1;
                    MEM_RDATA = rdata;
                end
                @(posedge CLK); #1;
                MEM_ACK = 1'b0;
                MEM_RDATA = $urandom;
            end
            if (timed) begin
                flt   = 1'b1;
                cause = 2'b10;
            end
        end
        chk({nm, ".resp_mem_req"}, 32'(MEM_REQ), 32'd0);
        chk({nm, ".done"}, 32'(DONE), 32'd1);
        chk({nm, ".fault"}, 32'(FAULT), 32'(flt));
        chk({nm, ".wb_valid"}, 32'(WB_VALID), 32'(ld && !flt));
        chk({nm, ".resp_ready"}, 32'(REQ_READY), 32'd0);
        if (flt) chk({nm, ".cause"}, 32'(FAULT_CAUSE), 32'(cause));
        if (ld && !flt) begin
            chk({nm, ".wb_data"}, WB_DATA, wb);
            chk({nm, ".wb_rd"}, 32'(WB_RD), 32'(rd));
        end
        @(posedge CLK); #1;
        chk({nm, ".done_pulse"}, 32'(DONE), 32'd0);
    endtask

    initial begin
        logic [6:0] op;
        int         r;
        int         ack;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.ready", 32'(REQ_READY), 32'd1);
        chk("rst.mem_req", 32'(MEM_REQ), 32'd0);
        chk("rst.mem_we", 32'(MEM_WE), 32'd0);
        chk("rst.mem_addr", MEM_ADDR, 32'd0);
        chk("rst.mem_wstrb", 32'(MEM_WSTRB), 32'd0);
        chk("rst.done", 32'(DONE), 32'd0);
        chk("rst.fault", 32'(FAULT), 32'd0);
        chk("rst.wb_valid", 32'(WB_VALID), 32'd0);
        chk("rst.wb_data", WB_DATA, 32'd0);
        RESET_N = 1'b1;
        @(posedge CLK); #1;

        // Directed cases
        run_txn("sb", OP_STORE, 3'b000, 32'h0000_1003, 32'hAABB_CC5A, 5'd3, 0, 32'd0);
        chk("sb.strb_const", 32'(MEM_WSTRB), 32'h8);
        chk("sb.wdata_const", MEM_WDATA, 32'h5A5A_5A5A);
        run_txn("lb", OP_LOAD, 3'b000, 32'h0000_2002, 32'd0, 5'd7, 0, 32'h12F0_3456);
        chk("lb.wb_const", WB_DATA, 32'hFFFF_FFF0);
        run_txn("lbu", OP_LOAD, 3'b100, 32'h0000_2002, 32'd0, 5'd9, 1, 32'h12F0_3456);
        chk("lbu.wb_const", WB_DATA, 32'h0000_00F0);
        run_txn("lh", OP_LOAD, 3'b001, 32'h0000_2002, 32'd0, 5'd11, 0, 32'h8001_7FFF);
        chk("lh.wb_const", WB_DATA, 32'hFFFF_8001);
        run_txn("lhu", OP_LOAD, 3'b101, 32'h0000_2000, 32'd0, 5'd12, 2, 32'h8001_7FFF);
        run_txn("sh", OP_STORE, 3'b001, 32'h0000_4002, 32'h1234_BEEF, 5'd0, 0, 32'd0);
        run_txn("sw", OP_STORE, 3'b010, 32'h0000_4008, 32'hDEAD_BEEF, 5'd0, 0, 32'd0);
        run_txn("lw_mis", OP_LOAD, 3'b010, 32'h0000_2001, 32'd0, 5'd1, 0, 32'd0);
        run_txn("st_ill", OP_STORE, 3'b011, 32'h0000_2000, 32'd0, 5'd1, 0, 32'd0);
        run_txn("ill_mis", OP_STORE, 3'b101, 32'h0000_2001, 32'd0, 5'd1, 0, 32'd0);
        run_txn("bad_op", 7'b0110011, 3'b000, 32'h0000_2000, 32'd0, 5'd1, 0, 32'd0);
        run_txn("tmo", OP_LOAD, 3'b010, 32'h0000_3000, 32'd0, 5'd4, -1, 32'd0);
        run_txn("ack_at_tmo", OP_LOAD, 3'b010, 32'h0000_3000, 32'd0, 5'd5, TO - 1, 32'hCAFE_F00D);

        // Reset in the middle of an access
        OPCODE = OP_LOAD; FUNCT3 = 3'b010; ADDR = 32'h0000_3000; RD = 5'd6;
        REQ_VALID = 1'b1;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        chk("rstmid.mem_req_before", 32'(MEM_REQ), 32'd1);
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        #1;
        chk("rstmid.mem_req", 32'(MEM_REQ), 32'd0);
        chk("rstmid.ready", 32'(REQ_READY), 32'd1);
        chk("rstmid.done", 32'(DONE), 32'd0);
        #2;
        RESET_N = 1'b1;
        MEM_ACK = 1'b1;
        MEM_RDATA = 32'h1111_2222;
        @(posedge CLK); #1;
        MEM_ACK = 1'b0;
        chk("late_ack.done", 32'(DONE), 32'd0);
        chk("late_ack.wb_valid", 32'(WB_VALID), 32'd0);
        chk("late_ack.mem_req", 32'(MEM_REQ), 32'd0);
        run_txn("after_rst", OP_LOAD, 3'b000, 32'h0000_3001, 32'd0, 5'd6, 0, 32'h0000_8000);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)      op = OP_LOAD;
            else if (r < 9) op = OP_STORE;
            else            op = 7'($urandom);
            r = int'($urandom_range(0, 9));
            if (r < 7)      ack = int'($urandom_range(0, TO - 1));
            else if (r < 9) ack = TO;
            else            ack = -1;
            run_txn($sformatf("rnd%0d", i), op, 3'($urandom), $urandom, $urandom,
                    5'($urandom), ack, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
